// File: rtl/gemm_pkg.sv
// gemm_pkg: shared types for the GEMM command dispatcher.
// - gemm_op_e    : funct3 encodings of GEMM-type instructions.
// - gemm_state_e : dispatcher FSM states.
// - gemm_cfg_t   : latched accelerator configuration (bases and dimensions).
// - op_needs_idle: ops that must wait for an idle FSM before taking effect.
package gemm_pkg;

  localparam int unsigned GemmAddrW = 32;
  localparam int unsigned GemmDimW  = 16;

  typedef enum logic [2:0] {
    OpSetA   = 3'b000,
    OpSetB   = 3'b001,
    OpSetC   = 3'b010,
    OpSetDim = 3'b011,
    OpStart  = 3'b100,
    OpWait   = 3'b101,
    OpRsvd6  = 3'b110,
    OpRsvd7  = 3'b111
  } gemm_op_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StRun    = 2'd2,
    StDone   = 2'd3
  } gemm_state_e;

  typedef struct packed {
    logic [GemmAddrW-1:0] a_base;
    logic [GemmAddrW-1:0] b_base;
    logic [GemmAddrW-1:0] c_base;
    logic [GemmDimW-1:0]  m;
    logic [GemmDimW-1:0]  n;
    logic [GemmDimW-1:0]  k;
  } gemm_cfg_t;

  // Reserved encodings never touch config or the accelerator, so they never stall.
  function automatic logic op_needs_idle(gemm_op_e op);
    return (op != OpRsvd6) && (op != OpRsvd7);
  endfunction

endpackage

// File: rtl/gemm_cfg_regs.sv
// gemm_cfg_regs: GEMM configuration register bank.
// Ports:
//   clk, rst  - core clock, synchronous active-high reset (clears all fields)
//   wr_en     - write strobe for an accepted SET_* op
//   op        - decoded op selecting which field(s) to write
//   rs1_val   - source of base addresses, M (low half) and N (high half)
//   rs2_val   - source of K (low half)
//   cfg       - current register contents, drives the accelerator fields
module gemm_cfg_regs
  import gemm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  gemm_op_e        op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output gemm_cfg_t       cfg
);

  gemm_cfg_t cfg_q, cfg_d;

  always_comb begin
    cfg_d = cfg_q;
    if (wr_en) begin
      case (op)
        OpSetA:   cfg_d.a_base = rs1_val[GemmAddrW-1:0];
        OpSetB:   cfg_d.b_base = rs1_val[GemmAddrW-1:0];
        OpSetC:   cfg_d.c_base = rs1_val[GemmAddrW-1:0];
        OpSetDim: begin
          cfg_d.m = rs1_val[GemmDimW-1:0];
          cfg_d.n = rs1_val[2*GemmDimW-1:GemmDimW];
          cfg_d.k = rs2_val[GemmDimW-1:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cfg_q <= '0;
    else     cfg_q <= cfg_d;
  end

  assign cfg = cfg_q;

  // Upper half of rs2 carries nothing for SET_DIM.
  logic unused_rs2;
  assign unused_rs2 = ^rs2_val[XLEN-1:GemmDimW];

endmodule

// File: rtl/gemm_cmd_dispatch.sv
// gemm_cmd_dispatch: execute-stage responder for GEMM-type instructions.
// Latches config from rs1/rs2, launches the accelerator via a valid/ready start
// handshake, stalls the pipeline while busy and pulses gemm_done on completion.
// Optional feature macro: GEMM_PERF_CNT_EN adds the perf_cycles output, a
// saturating count of LAUNCH+RUN cycles cleared on each accepted START.
// Ports:
//   clk, rst                  - core clock, synchronous active-high reset
//   gemm_instr_vld            - GEMM instruction present in execute
//   gemm_funct3               - instruction[14:12]
//   rs1_val, rs2_val          - forwarded operands
//   flush                     - discards the instruction in execute
//   gemm_stall                - combinational pipeline hold
//   gemm_done                 - one-cycle completion pulse
//   acc_start_vld/rdy         - accelerator start handshake
//   acc_a/b/c_base, acc_m/n/k - accelerator config, stable while busy
//   acc_done                  - accelerator completion pulse
//   perf_cycles               - (GEMM_PERF_CNT_EN only) busy-cycle counter
//   cfg_err                   - sticky error: reserved op or zero-dimension START
// Field widths follow gemm_pkg; ADDR_W/DIM_W must match GemmAddrW/GemmDimW.
module gemm_cmd_dispatch
  import gemm_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = GemmAddrW,
  parameter int unsigned DIM_W  = GemmDimW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gemm_instr_vld,
  input  logic [2:0]        gemm_funct3,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  input  logic              flush,
  output logic              gemm_stall,
  output logic              gemm_done,
  output logic              acc_start_vld,
  input  logic              acc_start_rdy,
  output logic [ADDR_W-1:0] acc_a_base,
  output logic [ADDR_W-1:0] acc_b_base,
  output logic [ADDR_W-1:0] acc_c_base,
  output logic [DIM_W-1:0]  acc_m,
  output logic [DIM_W-1:0]  acc_n,
  output logic [DIM_W-1:0]  acc_k,
  input  logic              acc_done,
`ifdef GEMM_PERF_CNT_EN
  output logic [31:0]       perf_cycles,
`endif
  output logic              cfg_err
);

  gemm_state_e state_q, state_d;
  gemm_op_e    op;
  gemm_cfg_t   cfg;
  logic        accept;
  logic        start_acc;
  logic        cfg_wr;
  logic        dims_ok;
  logic        err_set;
  logic        cfg_err_q;

  assign op = gemm_op_e'(gemm_funct3);

  // Anything touching config or the accelerator waits for IDLE, so config is
  // frozen for the whole time the accelerator may be reading it.
  assign gemm_stall = gemm_instr_vld && !flush && (state_q != StIdle) && op_needs_idle(op);
  assign accept     = gemm_instr_vld && !flush && !gemm_stall;
  assign start_acc  = accept && (op == OpStart);
  assign cfg_wr     = accept && ((op == OpSetA) || (op == OpSetB) ||
                                 (op == OpSetC) || (op == OpSetDim));
  assign dims_ok    = (cfg.m != '0) && (cfg.n != '0) && (cfg.k != '0);

  gemm_cfg_regs #(
    .XLEN (XLEN)
  ) u_cfg_regs (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cfg_wr),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .cfg     (cfg)
  );

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_acc) begin
          if (dims_ok) begin
            state_d = StLaunch;
          end else begin
            // Degenerate GEMM: complete immediately without launching.
            state_d = StDone;
            err_set = 1'b1;
          end
        end
      end
      StLaunch: if (acc_start_rdy) state_d = StRun;
      StRun:    if (acc_done)      state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (accept && !op_needs_idle(op)) err_set = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_err_q | err_set;
    end
  end

`ifdef GEMM_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (start_acc) begin
      perf_q <= '0;
    end else if (((state_q == StLaunch) || (state_q == StRun)) && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

  assign acc_start_vld = (state_q == StLaunch);
  assign gemm_done     = (state_q == StDone);
  assign cfg_err       = cfg_err_q;
  assign acc_a_base    = cfg.a_base;
  assign acc_b_base    = cfg.b_base;
  assign acc_c_base    = cfg.c_base;
  assign acc_m         = cfg.m;
  assign acc_n         = cfg.n;
  assign acc_k         = cfg.k;

endmodule
